// File: rtl/id_issue_stage_if.sv
// ID/EX stage bus: registered decode/issue entry plus the EX-side ready.
// The issue stage drives it through the master modport; EX consumes it through slave.
interface id_issue_stage_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CTRLW = 10
);
  localparam int AW = $clog2(NREGS);

  logic             valid;
  logic             ready;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  port_a;
  logic [XLEN-1:0]  port_b;
  logic [XLEN-1:0]  store_data;
  logic [3:0]       alu_op;
  logic [AW-1:0]    waddr;
  logic             we;
  logic             load_op;
  logic [CTRLW-1:0] ctrl;
  logic             bad_target;

  modport master (
    output valid, pc, port_a, port_b, store_data, alu_op,
           waddr, we, load_op, ctrl, bad_target,
    input  ready
  );

  modport slave (
    input  valid, pc, port_a, port_b, store_data, alu_op,
           waddr, we, load_op, ctrl, bad_target,
    output ready
  );
endinterface

// File: rtl/id_issue_stage.sv
// Decode/issue stage: operand forwarding, load-use interlock, branch resolution,
// wrong-path drop and ID/EX register. Optional branch counters: ID_BRANCH_STATS_EN.
module id_issue_stage #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NFWD  = 2,
  parameter  int CTRLW = 10,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  logic [XLEN-1:0]      id_pc_i,
  input  logic [AW-1:0]        id_rs1_i,
  input  logic [AW-1:0]        id_rs2_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [AW-1:0]        id_rd_i,
  input  logic                 id_we_i,
  input  logic [XLEN-1:0]      id_imm_i,
  input  logic                 id_porta_sel_i,
  input  logic                 id_portb_sel_i,
  input  logic                 id_jump_op_i,
  input  logic                 id_jalr_op_i,
  input  logic                 id_branch_op_i,
  input  logic [2:0]           id_cmp_op_i,
  input  logic                 id_load_op_i,
  input  logic [3:0]           id_alu_op_i,
  input  logic [CTRLW-1:0]     id_ctrl_i,

  input  logic [XLEN-1:0]      rf_drs1_i,
  input  logic [XLEN-1:0]      rf_drs2_i,

  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD*AW-1:0]   fwd_waddr_i,
  input  logic [NFWD*XLEN-1:0] fwd_data_i,
  input  logic [NFWD-1:0]      fwd_load_i,

  input  logic                 flush_i,

  id_issue_stage_if.master     ex,

  output logic                 redirect_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  output logic [31:0]          perf_branch_cnt_o,
  output logic [31:0]          perf_taken_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_SHADOW
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            pending;
  } operand_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  port_a;
    logic [XLEN-1:0]  port_b;
    logic [XLEN-1:0]  store_data;
    logic [3:0]       alu_op;
    logic [AW-1:0]    waddr;
    logic             we;
    logic             load_op;
    logic [CTRLW-1:0] ctrl;
    logic             bad_target;
  } ex_entry_t;

  state_t    state, state_next;
  operand_t  op1, op2;
  ex_entry_t entry_d, entry_q;
  logic      ex_valid_q;

  logic            hazard;
  logic            cmp_true;
  logic            taken;
  logic            bad_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            ready;
  logic            fire;
  logic            issue;

  // Lowest-index producer wins, so scan from the oldest down and let younger
  // matches overwrite. x0 is hard-wired and never forwarded or stalled on.
  function automatic operand_t resolve(
    input logic [AW-1:0]        addr,
    input logic [XLEN-1:0]      rf_data,
    input logic [NFWD-1:0]      f_valid,
    input logic [NFWD*AW-1:0]   f_waddr,
    input logic [NFWD*XLEN-1:0] f_data,
    input logic [NFWD-1:0]      f_load
  );
    operand_t res;
    res.data    = rf_data;
    res.pending = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (f_valid[i] && (f_waddr[i*AW +: AW] == addr)) begin
        res.data    = f_data[i*XLEN +: XLEN];
        res.pending = f_load[i];
      end
    end
    if (addr == '0) begin
      res.data    = '0;
      res.pending = 1'b0;
    end
    return res;
  endfunction

  assign op1 = resolve(id_rs1_i, rf_drs1_i, fwd_valid_i, fwd_waddr_i, fwd_data_i, fwd_load_i);
  assign op2 = resolve(id_rs2_i, rf_drs2_i, fwd_valid_i, fwd_waddr_i, fwd_data_i, fwd_load_i);

  assign hazard = (id_rs1_used_i & op1.pending) | (id_rs2_used_i & op2.pending);

  // Branch compare on the forwarded operands, funct3 encoding.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    cmp_true = 1'b0;
    case (id_cmp_op_i)
      3'b000:  cmp_true = (op1.data == op2.data);
      3'b001:  cmp_true = (op1.data != op2.data);
      3'b100:  cmp_true = ($signed(op1.data) <  $signed(op2.data));
      3'b101:  cmp_true = ($signed(op1.data) >= $signed(op2.data));
      3'b110:  cmp_true = (op1.data <  op2.data);
      3'b111:  cmp_true = (op1.data >= op2.data);
      default: cmp_true = 1'b0;
    endcase
  end

  assign taken      = id_jump_op_i | id_jalr_op_i | (id_branch_op_i & cmp_true);
  assign jalr_sum   = op1.data + id_imm_i;
  assign target     = id_jalr_op_i ? {jalr_sum[XLEN-1:1], 1'b0} : (id_pc_i + id_imm_i);
  assign bad_target = taken & (target[1:0] != 2'b00);

  // Handshake and FSM next state. In SHADOW the beat is swallowed, so it must
  // not redirect, count, or reach EX; flush overrides everything.
  always_comb begin
    state_next = state;
    ready      = (state == ST_SHADOW) ? 1'b1 : (~hazard & (~ex_valid_q | ex.ready));
    fire       = id_valid_i & ready & ~flush_i;
    issue      = fire & (state != ST_SHADOW);

    case (state)
      ST_RUN, ST_STALL: begin
        if (hazard)              state_next = ST_STALL;
        else if (issue && taken) state_next = ST_SHADOW;
        else                     state_next = ST_RUN;
      end
      ST_SHADOW: begin
        if (fire) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase

    if (flush_i) state_next = ST_RUN;
  end

  assign id_ready_o    = ready;
  assign redirect_o    = issue & taken;
  assign redirect_pc_o = target;

  always_comb begin
    entry_d.pc         = id_pc_i;
    entry_d.port_a     = id_porta_sel_i ? id_pc_i  : op1.data;
    entry_d.port_b     = id_portb_sel_i ? id_imm_i : op2.data;
    entry_d.store_data = op2.data;
    entry_d.alu_op     = id_alu_op_i;
    entry_d.waddr      = id_rd_i;
    entry_d.we         = id_we_i;
    entry_d.load_op    = id_load_op_i;
    entry_d.ctrl       = id_ctrl_i;
    entry_d.bad_target = bad_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) state <= ST_RUN;
    else      state <= state_next;
  end

  // ID/EX register. Payload holds across bubbles; only valid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      entry_q    <= '0;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (issue) begin
      ex_valid_q <= 1'b1;
      entry_q    <= entry_d;
    end else if (ex.ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex.valid      = ex_valid_q;
  assign ex.pc         = entry_q.pc;
  assign ex.port_a     = entry_q.port_a;
  assign ex.port_b     = entry_q.port_b;
  assign ex.store_data = entry_q.store_data;
  assign ex.alu_op     = entry_q.alu_op;
  assign ex.waddr      = entry_q.waddr;
  assign ex.we         = entry_q.we;
  assign ex.load_op    = entry_q.load_op;
  assign ex.ctrl       = entry_q.ctrl;
  assign ex.bad_target = entry_q.bad_target;

`ifdef ID_BRANCH_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] taken_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (issue && id_branch_op_i) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (cmp_true) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign perf_branch_cnt_o = branch_cnt_q;
  assign perf_taken_cnt_o  = taken_cnt_q;
`else
  assign perf_branch_cnt_o = '0;
  assign perf_taken_cnt_o  = '0;
`endif

endmodule
